// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the future receiver.
// The state encoding is fixed so both directions decode state the same way.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 104;   // 12 MHz / 115200
    localparam int DATA_BITS            = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uartState_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic evenParity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 while enabled; tick is high during the last
// cycle of each bit period and the count restarts from zero after it.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              W    = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0]    LAST = W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : gBadClksPerBit
        $error("uart_bit_timer: CLKS_PER_BIT must be >= 2");
    end

    logic [W-1:0] count;

    assign tick = enable && (count == LAST);

    // Bit-period counter; clear wins so a new frame always starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 1 start bit, 8 data bits LSB first, 1 stop bit.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN
// is defined (frame becomes 11 bits).
//
// state  | meaning
// IDLE   | line high, waiting for byteReady
// START  | driving the start bit (low)
// DATA   | shifting out the latched byte, LSB first
// PARITY | driving the even parity bit (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit (high), then back to IDLE
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 byteReady,
    input  logic [DATA_BITS-1:0] dataIn,
    output logic                 byteSending,
    output logic                 uartTx
);

    if (CLKS_PER_BIT < 2) begin : gBadClksPerBit
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uartState_e           state;
    logic [DATA_BITS-1:0] shiftReg;
    logic [2:0]           bitCount;
    logic                 bitTick;
    logic                 timerClear;
    logic                 timerEnable;
`ifdef UART_TX_PARITY_EN
    logic                 parityBit;
`endif

    assign timerClear  = (state == IDLE) && byteReady;
    assign timerEnable = (state != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) uBitTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timerClear),
        .enable (timerEnable),
        .tick   (bitTick)
    );

    // Frame sequencer; every line-level change happens on a bit-timer tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shiftReg    <= '0;
            bitCount    <= '0;
            uartTx      <= 1'b1;
            byteSending <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    uartTx      <= 1'b1;
                    byteSending <= 1'b0;
                    if (byteReady) begin
                        shiftReg    <= dataIn;
                        bitCount    <= '0;
                        uartTx      <= 1'b0;
                        byteSending <= 1'b1;
                        state       <= START;
`ifdef UART_TX_PARITY_EN
                        parityBit   <= evenParity(dataIn);
`endif
                    end
                end
                START: begin
                    if (bitTick) begin
                        uartTx   <= shiftReg[0];
                        shiftReg <= {1'b0, shiftReg[DATA_BITS-1:1]};
                        bitCount <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        if (bitCount == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            uartTx <= parityBit;
                            state  <= PARITY;
`else
                            uartTx <= 1'b1;
                            state  <= STOP;
`endif
                        end else begin
                            uartTx   <= shiftReg[0];
                            shiftReg <= {1'b0, shiftReg[DATA_BITS-1:1]};
                            bitCount <= bitCount + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bitTick) begin
                        uartTx <= 1'b1;
                        state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bitTick) begin
                        byteSending <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    uartTx      <= 1'b1;
                    byteSending <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT = 4.
// Expected line levels come from a frame model built from the byte value.
module tb_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int MAX_CYC  = 12 * C + 8;
    localparam int WAIT_MAX = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       byteReady = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       byteSending;
    logic       uartTx;

    int errors = 0;
    int checks = 0;

    logic capLine [0:MAX_CYC-1];
    int   capLen;
    int   capPre;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byteReady   (byteReady),
        .dataIn      (dataIn),
        .byteSending (byteSending),
        .uartTx      (uartTx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic expBit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return (($countones(d) % 2) == 1);
`endif
        return 1'b1;
    endfunction

    // Level held on the line for frame bit b, or x if it was not stable for C cycles.
    function automatic logic lineBit(input int b);
        logic v;
        if ((b + 1) * C > capLen) return 1'bx;
        v = capLine[b*C];
        for (int k = 1; k < C; k++)
            if (capLine[b*C+k] !== v) return 1'bx;
        return v;
    endfunction

    // Records uartTx at each falling edge while byteSending is high.
    task automatic captureFrame();
        capLen = 0;
        capPre = 0;
        @(negedge clk);
        while (byteSending !== 1'b1 && capPre < WAIT_MAX) begin
            capPre++;
            @(negedge clk);
        end
        if (byteSending !== 1'b1) return;
        while (byteSending === 1'b1 && capLen < MAX_CYC) begin
            capLine[capLen] = uartTx;
            capLen++;
            @(negedge clk);
        end
    endtask

    // Counts cycles in which the line is not idle.
    task automatic measureIdle(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (byteSending !== 1'b0 || uartTx !== 1'b1) bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uartTx !== 1'b1) begin
            errors++; $display("FAIL reset_uartTx got=%b exp=1", uartTx);
        end
        checks++;
        if (byteSending !== 1'b0) begin
            errors++; $display("FAIL reset_byteSending got=%b exp=0", byteSending);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        int bad;
        @(posedge clk); #1;
        dataIn = 8'h50; byteReady = 1'b1;
        @(negedge clk);
        checks++;
        if (byteSending !== 1'b0) begin
            errors++; $display("FAIL single_pre_accept got=%b exp=0", byteSending);
        end
        fork
            captureFrame();
            begin @(posedge clk); #1 byteReady = 1'b0; end
        join
        checks++;
        if (capPre != 0) begin
            errors++; $display("FAIL single_latency got=%0d exp=0", capPre);
        end
        checks++;
        if (capLen != FRAME_BITS * C) begin
            errors++; $display("FAIL single_len got=%0d exp=%0d", capLen, FRAME_BITS * C);
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            checks++;
            if (lineBit(b) !== expBit(8'h50, b)) begin
                errors++; $display("FAIL single_bit%0d got=%b exp=%b", b, lineBit(b), expBit(8'h50, b));
            end
        end
        measureIdle(2 * C, bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL single_idle got=%0d exp=0 busy cycles", bad);
        end
    endtask

    task automatic test_handshake();
        int bad;
        @(posedge clk); #1;
        dataIn = 8'h3F; byteReady = 1'b1;
        fork
            captureFrame();
            begin
                for (int i = 0; i < WAIT_MAX; i++) begin
                    @(negedge clk);
                    if (byteSending === 1'b1) break;
                end
                byteReady = 1'b0;
            end
        join
        checks++;
        if (capLen != FRAME_BITS * C) begin
            errors++; $display("FAIL handshake_len got=%0d exp=%0d", capLen, FRAME_BITS * C);
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            checks++;
            if (lineBit(b) !== expBit(8'h3F, b)) begin
                errors++; $display("FAIL handshake_bit%0d got=%b exp=%b", b, lineBit(b), expBit(8'h3F, b));
            end
        end
        measureIdle(3 * C, bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL handshake_single_frame got=%0d exp=0 busy cycles", bad);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        dataIn = 8'h55; byteReady = 1'b1;
        fork
            captureFrame();
            begin
                for (int i = 0; i < WAIT_MAX; i++) begin
                    @(negedge clk);
                    if (byteSending === 1'b1) break;
                end
                dataIn = 8'hAA;
            end
        join
        checks++;
        if (capLen != FRAME_BITS * C) begin
            errors++; $display("FAIL b2b_len1 got=%0d exp=%0d", capLen, FRAME_BITS * C);
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            checks++;
            if (lineBit(b) !== expBit(8'h55, b)) begin
                errors++; $display("FAIL b2b_f1_bit%0d got=%b exp=%b", b, lineBit(b), expBit(8'h55, b));
            end
        end
        fork
            captureFrame();
            begin
                for (int i = 0; i < WAIT_MAX; i++) begin
                    @(negedge clk);
                    if (byteSending === 1'b1) break;
                end
                byteReady = 1'b0;
            end
        join
        checks++;
        if (capPre + 1 != 1) begin
            errors++; $display("FAIL b2b_gap got=%0d exp=1 low cycles", capPre + 1);
        end
        checks++;
        if (capLen != FRAME_BITS * C) begin
            errors++; $display("FAIL b2b_len2 got=%0d exp=%0d", capLen, FRAME_BITS * C);
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            checks++;
            if (lineBit(b) !== expBit(8'hAA, b)) begin
                errors++; $display("FAIL b2b_f2_bit%0d got=%b exp=%b", b, lineBit(b), expBit(8'hAA, b));
            end
        end
    endtask

    task automatic test_mid_frame_change();
        @(posedge clk); #1;
        dataIn = 8'h0F; byteReady = 1'b1;
        fork
            captureFrame();
            begin
                @(posedge clk); #1 byteReady = 1'b0;
                repeat (3 * C + 1) @(posedge clk);
                #1 dataIn = 8'hF0;
            end
        join
        checks++;
        if (capLen != FRAME_BITS * C) begin
            errors++; $display("FAIL midchange_len got=%0d exp=%0d", capLen, FRAME_BITS * C);
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            checks++;
            if (lineBit(b) !== expBit(8'h0F, b)) begin
                errors++; $display("FAIL midchange_bit%0d got=%b exp=%b", b, lineBit(b), expBit(8'h0F, b));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk); #1;
        dataIn = 8'hF0; byteReady = 1'b1;
        @(posedge clk); #1 byteReady = 1'b0;
        repeat (4 * C + 1) @(posedge clk);
        #2;
        checks++;
        if (uartTx !== 1'b0 || byteSending !== 1'b1) begin
            errors++; $display("FAIL rstmid_before got=%b%b exp=01 (uartTx,byteSending)", uartTx, byteSending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (uartTx !== 1'b1 || byteSending !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got=%b%b exp=10 (uartTx,byteSending)", uartTx, byteSending);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        dataIn = 8'h01; byteReady = 1'b1;
        fork
            captureFrame();
            begin @(posedge clk); #1 byteReady = 1'b0; end
        join
        checks++;
        if (capLen != FRAME_BITS * C) begin
            errors++; $display("FAIL rstmid_len got=%0d exp=%0d", capLen, FRAME_BITS * C);
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            checks++;
            if (lineBit(b) !== expBit(8'h01, b)) begin
                errors++; $display("FAIL rstmid_bit%0d got=%b exp=%b", b, lineBit(b), expBit(8'h01, b));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         gap;
        for (int n = 0; n < 6; n++) begin
            d   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            @(posedge clk); #1;
            dataIn = d; byteReady = 1'b1;
            fork
                captureFrame();
                begin @(posedge clk); #1 byteReady = 1'b0; dataIn = ~d; end
            join
            checks++;
            if (capLen != FRAME_BITS * C) begin
                errors++; $display("FAIL rand%0d_len got=%0d exp=%0d", n, capLen, FRAME_BITS * C);
            end
            for (int b = 0; b < FRAME_BITS; b++) begin
                checks++;
                if (lineBit(b) !== expBit(d, b)) begin
                    errors++; $display("FAIL rand%0d_bit%0d data=%h got=%b exp=%b", n, b, d, lineBit(b), expBit(d, b));
                end
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       par  [2];
        vals[0] = 8'h07; par[0] = 1'b1;
        vals[1] = 8'h50; par[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            dataIn = vals[n]; byteReady = 1'b1;
            fork
                captureFrame();
                begin @(posedge clk); #1 byteReady = 1'b0; end
            join
            checks++;
            if (capLen != 11 * C) begin
                errors++; $display("FAIL parity%0d_len got=%0d exp=%0d", n, capLen, 11 * C);
            end
            checks++;
            if (lineBit(9) !== par[n]) begin
                errors++; $display("FAIL parity%0d_bit got=%b exp=%b", n, lineBit(9), par[n]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_handshake();
        test_back_to_back();
        repeat (2 * C) @(posedge clk);
        test_mid_frame_change();
        test_reset_mid_frame();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that turns the command responder's byte output into an 8N1 line.
- Sits between the responder's dataOut/byteReadyOut pair and the FPGA TX pin.
- Implements the byteSending handshake the responder uses to clear its request and re-arm its receive path.
- Fixed framing: 1 start bit, 8 data bits LSB first, 1 stop bit; line idles high.

Parameters:
- CLKS_PER_BIT, 104: clk cycles per serial bit (12 MHz / 115200). Must be >= 2; elaboration-time check fails otherwise.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- byteReady  input  1  request to send dataIn; level-sensitive, sampled only in IDLE
- dataIn  input  8  byte to transmit; latched on acceptance
- byteSending  output  1  high for the whole frame of an accepted byte
- uartTx  output  1  serial line; idle high

Behaviour:
- Reset values: uartTx=1, byteSending=0, state=IDLE, counters=0. Reset is asynchronous; asserting it mid-frame aborts the frame and drives uartTx high immediately.
- All outputs are registered.
- States: IDLE -> START -> DATA -> STOP -> IDLE. PARITY sits between DATA and STOP only with the optional feature.
- Acceptance: in IDLE, byteReady=1 at edge k. At edge k:
  - latch dataIn into the shift register;
  - state<=START, uartTx<=0, byteSending<=1;
  - clear the bit-timer and bit counter.
- Bit timing: each line bit holds exactly CLKS_PER_BIT cycles. A timer counts 0..CLKS_PER_BIT-1; the bit advances on the terminal count.
- DATA: 3-bit counter 0..7. uartTx = shiftReg[0], shift right per bit. Leave on count 7 terminal.
- STOP: uartTx=1 for CLKS_PER_BIT cycles. On terminal count: state<=IDLE, byteSending<=0.
- Frame length: byteSending is high exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Back-to-back sends: IDLE always lasts at least one cycle, so byteSending is low for at least one cycle between frames. If byteReady is still high then, the next frame starts on the following edge.
- Ignored inputs: byteReady and dataIn changes during a frame are ignored; there is no queueing. The requester must drop byteReady once it sees byteSending.
- Timer width is $clog2(CLKS_PER_BIT). No wrap beyond the terminal count.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA. uartTx = XOR of the latched byte (even parity), held for CLKS_PER_BIT cycles. Frame is 11 bits.
- Undefined: no PARITY state or logic; 8N1 framing only.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams IDLE/START/DATA/PARITY/STOP;
  - default CLKS_PER_BIT;
  - DATA_BITS=8.
- The future uart_rx reuses this package.
- One natural sub-module: uart_bit_timer.
  - Inputs: clear, enable.
  - Output: one-cycle terminal-count pulse.
  - Parameterized by CLKS_PER_BIT; shared with the receiver.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Single byte: byteReady pulse 1 cycle with dataIn=0x50 ('P'). Required response:
  - uartTx levels, 4 cycles each: 0 | 0,0,0,0,1,0,1,0 | 1;
  - byteSending high exactly 40 cycles, starting the cycle after acceptance.
- Handshake with the responder: byteReady held until byteSending rises, then dropped. Exactly one frame ('?'=0x3F: 0|1,1,1,1,1,1,0,0|1), then uartTx stays high.
- Back-to-back: byteReady held high, dataIn=0x55 then 0xAA. Required response:
  - two complete frames;
  - byteSending low exactly 1 cycle between them;
  - second frame carries 0xAA.
- Mid-frame change: dataIn switched from 0x0F to 0xF0 during data bit 2. Transmitted bits still 1,1,1,1,0,0,0,0.
- Reset mid-frame: rst_n low during data bit 3. Required response:
  - uartTx=1 and byteSending=0 before the next clk edge;
  - after release, the next byteReady with 0x01 yields a clean full frame.
- Parity (UART_TX_PARITY_EN defined): dataIn=0x07 gives parity bit 1; 0x50 gives 0. byteSending high 44 cycles.
